// File: rtl/dtree_feature_link.sv
// Serial-in / parallel-out link between a sensor bitstream and a combinational printed
// decision tree: assembles a feature, waits out the tree's settle time, returns the class.
// Optional build macro DTREE_LINK_PARITY_EN adds a trailing even-parity bit to every frame.
//
// Handshake: res_valid/res_class are held stable from assertion until a cycle with
// res_valid & res_ready; res_valid drops on the following edge. res_ready is a don't-care
// while res_valid is low.

module dtree_feature_link #(
  parameter int FEAT_W        = 8,
  parameter int CLASS_W       = 4,
  parameter int PREC_BITS     = 8,
  parameter int MSB_FIRST     = 1,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               frame_start,
  input  logic               sdi,
  input  logic               sdi_valid,
  output logic [FEAT_W-1:0]  feat_out,
  input  logic [CLASS_W-1:0] class_in,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [CLASS_W-1:0] res_class,
  output logic               busy,
  output logic               frame_err,
  output logic [1:0]         state_dbg
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    SETTLE = 2'd2,
    HOLD   = 2'd3
  } state_t;

`ifdef DTREE_LINK_PARITY_EN
  localparam int NBITS = FEAT_W + 1;
`else
  localparam int NBITS = FEAT_W;
`endif
  localparam int CNT_W = $clog2(NBITS + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(NBITS - 1);
  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES);
  // Keeps the PREC_BITS MSBs; the truncated LSBs reach the tree as zeros.
  localparam logic [FEAT_W-1:0] PREC_MASK =
    FEAT_W'(~((32'd1 << (FEAT_W - PREC_BITS)) - 32'd1));

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   bit_cnt, bit_cnt_nxt;
  logic [FEAT_W-1:0]  sreg, sreg_nxt, shifted;
  logic [3:0]         settle_cnt, settle_nxt;
  logic [FEAT_W-1:0]  feat_nxt;
  logic [CLASS_W-1:0] res_class_nxt;
  logic               res_valid_nxt;
  logic               err_nxt;

  assign shifted   = (MSB_FIRST != 0) ? {sreg[FEAT_W-2:0], sdi} : {sdi, sreg[FEAT_W-1:1]};
  assign state_dbg = state;

  always_comb begin
    state_nxt     = state;
    bit_cnt_nxt   = bit_cnt;
    sreg_nxt      = sreg;
    settle_nxt    = settle_cnt;
    feat_nxt      = feat_out;
    res_class_nxt = res_class;
    res_valid_nxt = res_valid;
    err_nxt       = 1'b0;
    case (state)
      IDLE: begin
        if (frame_start) begin
          state_nxt   = SHIFT;
          bit_cnt_nxt = '0;
          sreg_nxt    = '0;
        end
      end
      SHIFT: begin
        if (frame_start) begin
          // Restart wins over a coincident data bit, which is dropped.
          bit_cnt_nxt = '0;
          sreg_nxt    = '0;
          err_nxt     = 1'b1;
        end else if (sdi_valid) begin
          if (bit_cnt == LAST_BIT) begin
            bit_cnt_nxt = '0;
`ifdef DTREE_LINK_PARITY_EN
            if ((^sreg ^ sdi) == 1'b0) begin
              feat_nxt   = sreg & PREC_MASK;
              state_nxt  = SETTLE;
              settle_nxt = 4'd1;
            end else begin
              err_nxt   = 1'b1;
              state_nxt = IDLE;
            end
`else
            feat_nxt   = shifted & PREC_MASK;
            state_nxt  = SETTLE;
            settle_nxt = 4'd1;
`endif
          end else begin
            sreg_nxt    = shifted;
            bit_cnt_nxt = bit_cnt + 1'b1;
          end
        end
      end
      SETTLE: begin
        if (frame_start) err_nxt = 1'b1;
        if (settle_cnt == SETTLE_LAST) begin
          res_class_nxt = class_in;
          res_valid_nxt = 1'b1;
          state_nxt     = HOLD;
        end else begin
          settle_nxt = settle_cnt + 4'd1;
        end
      end
      HOLD: begin
        if (res_ready) begin
          res_valid_nxt = 1'b0;
          if (frame_start) begin
            state_nxt   = SHIFT;
            bit_cnt_nxt = '0;
            sreg_nxt    = '0;
          end else begin
            state_nxt = IDLE;
          end
        end else if (frame_start) begin
          err_nxt = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      bit_cnt    <= '0;
      sreg       <= '0;
      settle_cnt <= '0;
      feat_out   <= '0;
      res_class  <= '0;
      res_valid  <= 1'b0;
      frame_err  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_nxt;
      bit_cnt    <= bit_cnt_nxt;
      sreg       <= sreg_nxt;
      settle_cnt <= settle_nxt;
      feat_out   <= feat_nxt;
      res_class  <= res_class_nxt;
      res_valid  <= res_valid_nxt;
      frame_err  <= err_nxt;
      busy       <= (state_nxt != IDLE);
    end
  end

endmodule

// File: tb/tb_dtree_feature_link.sv
// Directed bench for dtree_feature_link: a default instance and a PREC_BITS=4/LSB-first
// instance share all inputs; expected values are hand-computed constants.

module tb_dtree_feature_link;

  logic       clk = 1'b0;
  logic       rst_n, frame_start, sdi, sdi_valid, res_ready;
  logic [3:0] class_in;

  logic [7:0] feat_a, feat_b;
  logic       rv_a, rv_b, busy_a, busy_b, err_a, err_b;
  logic [3:0] rc_a, rc_b;
  logic [1:0] st_a, st_b;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  dtree_feature_link dut_a (
    .clk(clk), .rst_n(rst_n), .frame_start(frame_start), .sdi(sdi), .sdi_valid(sdi_valid),
    .feat_out(feat_a), .class_in(class_in), .res_valid(rv_a), .res_ready(res_ready),
    .res_class(rc_a), .busy(busy_a), .frame_err(err_a), .state_dbg(st_a)
  );

  dtree_feature_link #(.PREC_BITS(4), .MSB_FIRST(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .frame_start(frame_start), .sdi(sdi), .sdi_valid(sdi_valid),
    .feat_out(feat_b), .class_in(class_in), .res_valid(rv_b), .res_ready(res_ready),
    .res_class(rc_b), .busy(busy_b), .frame_err(err_b), .state_dbg(st_b)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // Sends b[7] first; with gaps, an sdi_valid=0 cycle (with a junk sdi) precedes each bit.
  task automatic send_byte(input logic [7:0] b, input bit gaps, input bit par_flip);
    for (int i = 7; i >= 0; i--) begin
      if (gaps) begin
        sdi_valid = 1'b0;
        sdi = ~b[i];
        tick();
      end
      sdi = b[i];
      sdi_valid = 1'b1;
      tick();
    end
`ifdef DTREE_LINK_PARITY_EN
    sdi = (^b) ^ par_flip;
    sdi_valid = 1'b1;
    tick();
`endif
    sdi_valid = 1'b0;
    sdi = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_feat_a"}, feat_a, 8'h00);
    chk({tag, "_feat_b"}, feat_b, 8'h00);
    chk({tag, "_rv"}, {rv_a, rv_b}, 2'b00);
    chk({tag, "_rc"}, {rc_a, rc_b}, 8'h00);
    chk({tag, "_busy"}, {busy_a, busy_b}, 2'b00);
    chk({tag, "_err"}, {err_a, err_b}, 2'b00);
    chk({tag, "_state"}, {st_a, st_b}, 4'h0);
  endtask

  initial begin
    rst_n = 1'b0; frame_start = 1'b0; sdi = 1'b0; sdi_valid = 1'b0;
    res_ready = 1'b0; class_in = 4'h0;
    tick(); tick();
    chk_all_zero("reset");
    rst_n = 1'b1;
    tick();

    // Frame 1: 0xA5, class 7
    frame_start = 1'b1; tick(); frame_start = 1'b0;
    chk("f1_busy", {busy_a, busy_b}, 2'b11);
    chk("f1_state", st_a, 2'd1);
    class_in = 4'h7;
    send_byte(8'hA5, 1'b0, 1'b0);
    chk("f1_feat_a", feat_a, 8'hA5);
    chk("f1_feat_b", feat_b, 8'hA0);
    chk("f1_rv_early0", rv_a, 1'b0);
    tick();
    chk("f1_rv_early1", rv_a, 1'b0);
    chk("f1_busy_settle", busy_a, 1'b1);
    tick();
    chk("f1_rv", {rv_a, rv_b}, 2'b11);
    chk("f1_rc_a", rc_a, 4'h7);
    chk("f1_rc_b", rc_b, 4'h7);
    chk("f1_busy_hold", busy_a, 1'b1);
    res_ready = 1'b1; tick(); res_ready = 1'b0;
    chk("f1_rv_drop", {rv_a, rv_b}, 2'b00);
    chk("f1_busy_idle", {busy_a, busy_b}, 2'b00);
    chk("f1_state_idle", st_a, 2'd0);
    // res_ready while idle must not matter
    res_ready = 1'b1; tick(); res_ready = 1'b0;
    chk("idle_ready", {rv_a, st_a}, 3'b000);

    // Frame 2: bits 1,1,0,0,1,0,0,0 with sdi_valid gaps, then a long stall
    frame_start = 1'b1; tick(); frame_start = 1'b0;
    send_byte(8'hC8, 1'b1, 1'b0);
    chk("f2_feat_a", feat_a, 8'hC8);
    chk("f2_feat_b", feat_b, 8'h10);
    class_in = 4'h9;
    tick(); tick();
    chk("f2_rv", rv_a, 1'b1);
    chk("f2_rc", rc_a, 4'h9);
    for (int i = 0; i < 10; i++) begin
      class_in = (i % 2 == 0) ? 4'h6 : 4'h1;
      tick();
      chk("stall_rv", {rv_a, rv_b}, 2'b11);
      chk("stall_rc", {rc_a, rc_b}, 8'h99);
    end
    // Handshake together with frame_start: back-to-back frame
    res_ready = 1'b1; frame_start = 1'b1; tick();
    res_ready = 1'b0; frame_start = 1'b0;
    chk("b2b_rv", {rv_a, rv_b}, 2'b00);
    chk("b2b_err", {err_a, err_b}, 2'b00);
    chk("b2b_state", st_a, 2'd1);
    chk("b2b_busy", busy_a, 1'b1);

    // Restart after 5 bits, then full 0x3C
    for (int i = 0; i < 5; i++) begin
      sdi = i[0]; sdi_valid = 1'b1; tick();
    end
    chk("mid_feat_hold", {feat_a, feat_b}, 16'hC810);
    frame_start = 1'b1; sdi = 1'b1; tick();
    frame_start = 1'b0; sdi_valid = 1'b0;
    chk("restart_err", {err_a, err_b}, 2'b11);
    chk("restart_state", st_a, 2'd1);
    class_in = 4'h3;
    send_byte(8'h3C, 1'b0, 1'b0);
    chk("f3_feat_a", feat_a, 8'h3C);
    chk("f3_feat_b", feat_b, 8'h30);
    chk("f3_err_clear", err_a, 1'b0);
    // frame_start during SETTLE is ignored but flagged
    frame_start = 1'b1; tick(); frame_start = 1'b0;
    chk("settle_fs_err", {err_a, err_b}, 2'b11);
    chk("settle_fs_rv", rv_a, 1'b0);
    tick();
    chk("f3_rv", rv_a, 1'b1);
    chk("f3_rc", rc_a, 4'h3);
    chk("f3_err_drop", err_a, 1'b0);
    // frame_start in HOLD without handshake
    frame_start = 1'b1; tick(); frame_start = 1'b0;
    chk("hold_fs_err", err_a, 1'b1);
    chk("hold_fs_state", st_a, 2'd3);
    res_ready = 1'b1; tick(); res_ready = 1'b0;
    chk("f3_rv_drop", rv_a, 1'b0);
    tick(); tick();
    chk("f3_single", {rv_a, st_a}, 3'b000);

    // Reset during SETTLE
    frame_start = 1'b1; tick(); frame_start = 1'b0;
    send_byte(8'h5A, 1'b0, 1'b0);
    chk("f4_feat_a", feat_a, 8'h5A);
    chk("f4_feat_b", feat_b, 8'h50);
    chk("f4_settle", st_a, 2'd2);
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    chk_all_zero("rst_settle");
    tick();
    chk("rst_no_result", rv_a, 1'b0);

    // Frame after reset: 0x82, class E
    frame_start = 1'b1; tick(); frame_start = 1'b0;
    class_in = 4'hE;
    send_byte(8'h82, 1'b0, 1'b0);
    chk("f5_feat_a", feat_a, 8'h82);
    chk("f5_feat_b", feat_b, 8'h40);
    tick(); tick();
    chk("f5_rv", {rv_a, rv_b}, 2'b11);
    chk("f5_rc", {rc_a, rc_b}, 8'hEE);
    res_ready = 1'b1; tick(); res_ready = 1'b0;
    chk("f5_rv_drop", rv_a, 1'b0);

`ifdef DTREE_LINK_PARITY_EN
    // Good parity on 0xA5, then bad parity on 0x3C
    frame_start = 1'b1; tick(); frame_start = 1'b0;
    class_in = 4'h5;
    send_byte(8'hA5, 1'b0, 1'b0);
    chk("par_ok_feat", {feat_a, feat_b}, 16'hA5A0);
    chk("par_ok_err", err_a, 1'b0);
    tick(); tick();
    chk("par_ok_rv", rv_a, 1'b1);
    chk("par_ok_rc", rc_a, 4'h5);
    res_ready = 1'b1; tick(); res_ready = 1'b0;
    frame_start = 1'b1; tick(); frame_start = 1'b0;
    send_byte(8'h3C, 1'b0, 1'b1);
    chk("par_bad_err", {err_a, err_b}, 2'b11);
    chk("par_bad_feat", {feat_a, feat_b}, 16'hA5A0);
    chk("par_bad_state", {st_a, busy_a}, 3'b000);
    tick(); tick(); tick();
    chk("par_bad_rv", {rv_a, rv_b, err_a}, 3'b000);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
